// File: rtl/qar_can_fifo.sv
// CAN-style frame transmitter with register bus, loopback acceptance filter and RX FIFO.
// Frame timing is modelled only as a busy window; no bit-level serialisation.
module qar_can_fifo #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_write,
  input  logic        bus_read,
  input  logic [5:0]  addr_word,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  if (CLK_HZ <= 0 || RX_DEPTH < 2 || RX_DEPTH > 16 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_param_bad
    $error("qar_can_fifo: RX_DEPTH must be a power of two in 2..16 and CLK_HZ positive");
  end

  localparam int PW = $clog2(RX_DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;

  logic [1:0]  ctrl;
  logic [15:0] bittime;
  logic [7:0]  err_cnt;
  logic [3:0]  irq_en, irq_st;
  logic        ovf;
  logic [31:0] filter_id, filter_mask;
  logic [31:0] tx_id, tx_dlc, tx_data0, tx_data1;
  logic [31:0] snap_id, snap_dlc, snap_d0, snap_d1;
  logic [15:0] snap_bt, presc;
  logic [6:0]  bits_left;

  logic [3:0][31:0] mem [RX_DEPTH];
  logic [3:0][31:0] head;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [4:0]       count;

  logic wr_ctrl, wr_bt, wr_err, wr_ien, wr_ist, tx_cmd, rx_pop_cmd;
  logic accept, reject, abort, done, match, push_req, push, pop, ovf_set;
  logic empty, full;
  logic [3:0] dlc_n, irq_clr, irq_set;
  logic [6:0] frame_m1;
  logic [31:0] fdiff, status;

  assign wr_ctrl    = bus_write && addr_word == 6'h00;
  assign wr_bt      = bus_write && addr_word == 6'h02;
  assign wr_err     = bus_write && addr_word == 6'h03;
  assign wr_ien     = bus_write && addr_word == 6'h04;
  assign wr_ist     = bus_write && addr_word == 6'h05;
  assign tx_cmd     = bus_write && addr_word == 6'h0C;
  assign rx_pop_cmd = bus_write && addr_word == 6'h11;

  assign empty = count == 5'd0;
  assign full  = count == 5'(RX_DEPTH);

  assign accept = tx_cmd && state_q == IDLE && ctrl[0];
  assign reject = tx_cmd && !accept;
  assign abort  = state_q == BUSY && !ctrl[0];
  assign done   = state_q == BUSY && ctrl[0] && presc == 16'd0 && bits_left == 7'd0;

  // Any DLC of 8 or more counts as eight data bytes.
  assign dlc_n    = tx_dlc[3] ? 4'd8 : tx_dlc[3:0];
  assign frame_m1 = 7'd46 + {dlc_n, 3'b000};

  assign fdiff    = (snap_id ^ filter_id) & filter_mask;
  assign match    = fdiff[28:0] == 29'd0;
  assign push_req = done && ctrl[1] && match;
  assign pop      = rx_pop_cmd && !empty;
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;

  assign irq_clr = wr_ist ? wdata[3:0] : 4'd0;
  assign irq_set = {reject, ovf_set, done, push};
  assign irq     = |(irq_en & irq_st);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = BUSY;
      BUSY: if (abort || done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl        <= 2'b01;
      bittime     <= 16'h0013;
      err_cnt     <= '0;
      irq_en      <= '0;
      irq_st      <= '0;
      ovf         <= 1'b0;
      filter_id   <= '0;
      filter_mask <= '0;
      tx_id       <= '0;
      tx_dlc      <= '0;
      tx_data0    <= '0;
      tx_data1    <= '0;
    end else begin
      if (wr_ctrl) ctrl    <= wdata[1:0];
      if (wr_bt)   bittime <= wdata[15:0];
      if (wr_ien)  irq_en  <= wdata[3:0];
      if (bus_write) begin
        case (addr_word)
          6'h06: filter_id   <= wdata;
          6'h07: filter_mask <= wdata;
          6'h08: tx_id       <= wdata;
          6'h09: tx_dlc      <= wdata;
          6'h0A: tx_data0    <= wdata;
          6'h0B: tx_data1    <= wdata;
          default: ;
        endcase
      end
      irq_st <= (irq_st & ~irq_clr) | irq_set;
      ovf    <= (ovf & ~irq_clr[2]) | ovf_set;
      if (wr_err)                         err_cnt <= wdata[7:0];
      else if (ovf_set && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  // Prescaler runs BITTIME+1 cycles per bit; both counters reach zero on the last busy cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_id   <= '0;
      snap_dlc  <= '0;
      snap_d0   <= '0;
      snap_d1   <= '0;
      snap_bt   <= '0;
      presc     <= '0;
      bits_left <= '0;
    end else if (accept) begin
      snap_id   <= tx_id;
      snap_dlc  <= tx_dlc;
      snap_d0   <= tx_data0;
      snap_d1   <= tx_data1;
      snap_bt   <= bittime;
      presc     <= bittime;
      bits_left <= frame_m1;
    end else if (state_q == BUSY) begin
      if (presc == 16'd0) begin
        presc <= snap_bt;
        if (bits_left != 7'd0) bits_left <= bits_left - 7'd1;
      end else begin
        presc <= presc - 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {snap_d1, snap_d0, snap_dlc, snap_id};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    status       = '0;
    status[0]    = !empty;
    status[1]    = state_q == IDLE;
    status[2]    = ovf;
    status[3]    = state_q == BUSY;
    status[12:8] = count;
  end

  always_comb begin
    rdata = '0;
    if (bus_read) begin
      case (addr_word)
        6'h00: rdata = {30'd0, ctrl};
        6'h01: rdata = status;
        6'h02: rdata = {16'd0, bittime};
        6'h03: rdata = {24'd0, err_cnt};
        6'h04: rdata = {28'd0, irq_en};
        6'h05: rdata = {28'd0, irq_st};
        6'h06: rdata = filter_id;
        6'h07: rdata = filter_mask;
        6'h08: rdata = tx_id;
        6'h09: rdata = tx_dlc;
        6'h0A: rdata = tx_data0;
        6'h0B: rdata = tx_data1;
        6'h0D: rdata = empty ? 32'd0 : head[0];
        6'h0E: rdata = empty ? 32'd0 : head[1];
        6'h0F: rdata = empty ? 32'd0 : head[2];
        6'h10: rdata = empty ? 32'd0 : head[3];
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: doc/qar_can_fifo.md
QAR_CAN_FIFO -- requirements
Module: qar_can_fifo

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency (informational, no functional effect).
REQ-002 Parameter RX_DEPTH, default 4, RX FIFO entries, power of two, 2..16.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 bus_write  input  1  register write strobe, one cycle per access.
REQ-006 bus_read  input  1  register read strobe.
REQ-007 addr_word  input  6  word address.
REQ-008 wdata  input  32  write data.
REQ-009 rdata  output  32  combinational read data; 0 when bus_read=0 or unmapped address.
REQ-010 irq  output  1  |(IRQ_EN & IRQ_STATUS), combinational.

Function
REQ-011 Map: 0x0 CTRL RW (bit0 enable, bit1 loopback); 0x1 STATUS RO; 0x2 BITTIME RW (bits[15:0] prescale); 0x3 ERR_CNT RW (bits[7:0]); 0x4 IRQ_EN RW; 0x5 IRQ_STATUS W1C; 0x6 FILTER_ID RW; 0x7 FILTER_MASK RW; 0x8-0xB TX_ID/TX_DLC/TX_DATA0/TX_DATA1 RW; 0xC TX_CMD WO; 0xD-0x10 RX_ID/RX_DLC/RX_DATA0/RX_DATA1 RO (FIFO head); 0x11 RX_POP WO.
REQ-012 STATUS: bit0 rx_not_empty, bit1 tx_ready (=!busy), bit2 rx_overflow (sticky), bit3 tx_busy, bits[12:8] rx_count; other bits 0.
REQ-013 IRQ_STATUS bits: 0 rx_push, 1 tx_done, 2 rx_overflow, 3 tx_reject; bits[31:4] read 0.
REQ-014 FSM states IDLE, BUSY.
REQ-015 TX_CMD write in IDLE with CTRL.enable=1: snapshot TX_ID/DLC/DATA0/DATA1, enter BUSY next cycle.
REQ-016 TX_CMD write in BUSY or with enable=0: ignored, IRQ_STATUS[3] set.
REQ-017 frame_bits = 47 + 8*min(TX_DLC[3:0],8), using snapshotted DLC.
REQ-018 tx_busy high exactly frame_bits*(BITTIME[15:0]+1) cycles, starting the cycle after accepted TX_CMD; prescaler and bit counter loaded at accept; BITTIME writes during BUSY do not affect the current frame.
REQ-019 Completion cycle (last BUSY cycle): next cycle IDLE, IRQ_STATUS[1] set.
REQ-020 At completion with CTRL.loopback=1 and ((snap_id ^ FILTER_ID) & FILTER_MASK)[28:0]==0: push snapshot {id, dlc, data0, data1} into RX FIFO, IRQ_STATUS[0] set.
REQ-021 Loopback with filter miss: no push, no rx irq; tx_done still set.
REQ-022 CTRL.enable cleared while BUSY: abort to IDLE next cycle, no completion, no push, no irq.
REQ-023 RX_POP write with FIFO non-empty: discard head next cycle; empty: no effect.
REQ-024 RX head registers read 0 when FIFO empty.
REQ-025 Push when full without pop same cycle: frame dropped, STATUS[2] and IRQ_STATUS[2] set, ERR_CNT increments saturating at 255.
REQ-026 Push and pop same cycle: both performed, count unchanged; when full, push succeeds.
REQ-027 Pointers wrap modulo RX_DEPTH; rx_count range 0..RX_DEPTH.
REQ-028 IRQ_STATUS write clears bits where wdata=1; clearing bit2 also clears STATUS[2]; hardware set wins over clear in same cycle.
REQ-029 ERR_CNT software write wins over simultaneous increment.

Reset
REQ-030 On rst_n low: CTRL=0x1, BITTIME=0x13, all other registers 0, FIFO empty, FSM IDLE, STATUS=0x2, irq=0, rdata follows REQ-009.
REQ-031 Reset asserted mid-frame or mid-FIFO-activity discards all state without irq or push.

Verification
REQ-032 BITTIME=0, DLC=0, TX_CMD -> tx_busy exactly 47 cycles, then IRQ_STATUS=0x2, STATUS=0x2.
REQ-033 BITTIME=1, DLC=8, loopback, mask=0, IRQ_EN=0x1 -> busy 222 cycles; RX head equals TX regs; rx_count=1; irq=1.
REQ-034 FILTER_ID=0x123, MASK=0x7FF, TX_ID=0x124 loopback -> no push, IRQ_STATUS=0x2; TX_ID=0x123 -> push.
REQ-035 RX_DEPTH+1 loopback frames, no pop -> rx_count=RX_DEPTH, STATUS[2]=1, ERR_CNT=1, head is first frame; W1C 0x4 clears overflow.
REQ-036 TX_CMD during BUSY -> IRQ_STATUS[3]=1, frame timing unchanged; clear enable mid-frame -> IDLE, no tx_done.
REQ-037 FIFO full, RX_POP coincident with completion push -> rx_count stays RX_DEPTH, no overflow, head advances.
